mem_bus_arbiter: RTL and testbench

//  Shares the single 32-bit memory port between two requesters: port 0 = cpu, port 1 = loader/DMA.
//  The cpu uses memory for its register file as well as for data, so port 0 must never starve.

---
 rtl/mem_bus_pkg.sv | 16 +
 rtl/mem_arb_pick.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus arbiter: default address width,
// arbiter state encoding and requester port indices.
package mem_bus_pkg;

  localparam int unsigned AW_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the cpu (port 0) and loader (port 1).
// Build option MEM_ARB_RR_EN: ties go to the port that was not served last;
// otherwise ties always go to the cpu. Non-tie selection is the same in both.
module mem_arb_pick
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win
);

`ifdef MEM_ARB_RR_EN
  logic tie_win;
  assign tie_win = ~last;
`else
  logic tie_win;
  logic unused_last;
  assign tie_win     = PORT_CPU;
  assign unused_last = last;
`endif

  // Single requester wins outright; a tie is resolved by the selected mode.
  always_comb begin
    win = PORT_CPU;
    if (req == 2'b10) begin
      win = PORT_DMA;
    end else if (req == 2'b11) begin
      win = tie_win;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the single 32-bit memory port (port 0 = cpu,
// port 1 = loader/DMA). Each transaction is atomic: the grant is held until
// read data returns, the read times out, or the one-cycle write commits.
// Build option MEM_ARB_RR_EN selects round-robin tie breaking (see mem_arb_pick).
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned RD_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_rd,
  input  logic [1:0]    req_wr,
  input  logic [2*AW-1:0] req_addr,
  input  logic [63:0]   req_wr_data,
  output logic [1:0]    rd_valid,
  output logic [1:0]    wr_done,
  output logic [31:0]   rd_data,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wr_data,
  input  logic [31:0]   mem_rd_data,
  input  logic          mem_rd_valid,
  output logic          bus_err
);

  // A zero timeout disables the watchdog; keep the counter at least 1 bit wide.
  localparam int unsigned CntW = (RD_TIMEOUT > 0) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(RD_TIMEOUT);
  localparam logic ToEn = (RD_TIMEOUT != 0);

  arb_state_e      state_q, state_d;
  logic            gnt_q, gnt_d;
  logic            last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [1:0]    req;
  logic          win;
  logic          timed_out;
  logic [AW-1:0] gnt_addr;
  logic [31:0]   gnt_wdata;

  assign req       = req_rd | req_wr;
  assign timed_out = ToEn && (cnt_q == CntMax);
  assign gnt_addr  = (gnt_q == PORT_DMA) ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
  assign gnt_wdata = (gnt_q == PORT_DMA) ? req_wr_data[63:32] : req_wr_data[31:0];

  mem_arb_pick u_pick (
    .req  (req),
    .last (last_q),
    .win  (win)
  );

  // State, grant, last-served and timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and all outputs; memory side is driven from the grant.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    rd_valid    = 2'b00;
    wr_done     = 2'b00;
    rd_data     = 32'h0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '1;
    mem_wr_data = 32'h0;
    bus_err     = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          gnt_d = win;
          cnt_d = '0;
          if (req_wr[win]) begin
            state_d = ARB_WR;
            // Read and write together is a protocol violation; the write wins.
            bus_err = req_rd[win];
          end else begin
            state_d = ARB_RD;
          end
        end
      end
      ARB_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = gnt_addr;
        cnt_d     = cnt_q + CntW'(1);
        if (mem_rd_valid) begin
          rd_valid[gnt_q] = 1'b1;
          rd_data         = mem_rd_data;
          last_d          = gnt_q;
          state_d         = ARB_IDLE;
        end else if (timed_out) begin
          // Release the requester with zero data rather than hang the bus.
          rd_valid[gnt_q] = 1'b1;
          bus_err         = 1'b1;
          last_d          = gnt_q;
          state_d         = ARB_IDLE;
        end
      end
      ARB_WR: begin
        mem_wr_en      = 1'b1;
        mem_addr       = gnt_addr;
        mem_wr_data    = gnt_wdata;
        wr_done[gnt_q] = 1'b1;
        last_d         = gnt_q;
        state_d        = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single transactions plus
// hand-written reset, latency, tie, timeout and mid-read reset sequences.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_rd, req_wr;
  logic [31:0] req_addr;
  logic [63:0] req_wr_data;
  logic [1:0]  rd_valid, wr_done;
  logic [31:0] rd_data;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        bus_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .AW         (16),
    .RD_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_rd       (req_rd),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wr_data  (req_wr_data),
    .rd_valid     (rd_valid),
    .wr_done      (wr_done),
    .rd_data      (rd_data),
    .mem_rd_en    (mem_rd_en),
    .mem_wr_en    (mem_wr_en),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .bus_err      (bus_err)
  );

  typedef struct {
    logic        port;
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        exp_wr;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_rd       = 2'b00;
    req_wr       = 2'b00;
    req_addr     = 32'h0;
    req_wr_data  = 64'h0;
    mem_rd_data  = 32'h0;
    mem_rd_valid = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  initial begin
    logic [1:0] oh;
    logic       exp_port;

    //            port  rd    wr    addr      wdata         rdata         exp_wr exp_err
    vecs[0] = '{1'b1, 1'b0, 1'b1, 16'h0008, 32'h12345678, 32'h0,        1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h1234, 32'hA5A5A5A5, 32'h0,        1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h0080, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'hBEEF, 32'h0,        32'h0BADC0DE, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h0042, 32'h55AA55AA, 32'h0,        1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 16'hFFFE, 32'h01020304, 32'h0,        1'b1, 1'b1};

    // Reset values.
    clear_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst_rd_valid", rd_valid, 2'b00);
    chk("rst_wr_done", wr_done, 2'b00);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_mem_rd_en", mem_rd_en, 1'b0);
    chk("rst_mem_wr_en", mem_wr_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 16'hFFFF);
    chk("rst_mem_wr_data", mem_wr_data, 32'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_en", c), {mem_rd_en, mem_wr_en}, 2'b00);
      next_cycle();
    end

    // Table of single transactions, each started from IDLE.
    for (int i = 0; i < 6; i++) begin
      oh = vecs[i].port ? 2'b10 : 2'b01;
      req_rd[vecs[i].port] = vecs[i].rd;
      req_wr[vecs[i].port] = vecs[i].wr;
      req_addr    = vecs[i].port ? {vecs[i].addr, 16'h7777} : {16'h7777, vecs[i].addr};
      req_wr_data = vecs[i].port ? {vecs[i].wdata, 32'h66666666} : {32'h66666666, vecs[i].wdata};
      @(negedge clk);
      chk($sformatf("v%0d_accept_err", i), bus_err, vecs[i].exp_err);
      chk($sformatf("v%0d_idle_rd_en", i), mem_rd_en, 1'b0);
      next_cycle();
      @(negedge clk);
      chk($sformatf("v%0d_wr_en", i), mem_wr_en, vecs[i].exp_wr);
      chk($sformatf("v%0d_rd_en", i), mem_rd_en, !vecs[i].exp_wr);
      chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
      chk($sformatf("v%0d_wdata", i), mem_wr_data, vecs[i].exp_wr ? vecs[i].wdata : 32'h0);
      chk($sformatf("v%0d_wr_done", i), wr_done, vecs[i].exp_wr ? oh : 2'b00);
      next_cycle();
      if (!vecs[i].exp_wr) begin
        // Request dropped mid-read: the read must still complete.
        req_rd       = 2'b00;
        mem_rd_valid = 1'b1;
        mem_rd_data  = vecs[i].rdata;
        @(negedge clk);
        chk($sformatf("v%0d_rd_valid", i), rd_valid, oh);
        chk($sformatf("v%0d_rd_data", i), rd_data, vecs[i].rdata);
        chk($sformatf("v%0d_rd_err", i), bus_err, 1'b0);
        next_cycle();
      end
      clear_inputs();
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", i), {mem_rd_en, mem_wr_en, wr_done, rd_valid}, 6'b0);
      chk($sformatf("v%0d_idle_addr", i), mem_addr, 16'hFFFF);
      next_cycle();
    end

    // Port 0 read with two-cycle memory latency.
    req_rd   = 2'b01;
    req_addr = {16'h5555, 16'h0080};
    @(negedge clk);
    chk("lat_c0_rd_en", mem_rd_en, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("lat_c1_rd_en", mem_rd_en, 1'b1);
    chk("lat_c1_addr", mem_addr, 16'h0080);
    chk("lat_c1_rd_valid", rd_valid, 2'b00);
    next_cycle();
    @(negedge clk);
    chk("lat_c2_rd_en", mem_rd_en, 1'b1);
    chk("lat_c2_rd_valid", rd_valid, 2'b00);
    next_cycle();
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'hDEADBEEF;
    @(negedge clk);
    chk("lat_c3_rd_valid", rd_valid, 2'b01);
    chk("lat_c3_rd_data", rd_data, 32'hDEADBEEF);
    next_cycle();
    clear_inputs();
    @(negedge clk);
    chk("lat_c4_rd_en", mem_rd_en, 1'b0);
    next_cycle();

    // Continuous tie: alternate under round-robin, cpu always under fixed priority.
    do_reset();
    req_rd   = 2'b11;
    req_addr = {16'h0200, 16'h0100};
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_port = (i % 2 == 1);
`else
      exp_port = 1'b0;
`endif
      oh = exp_port ? 2'b10 : 2'b01;
      @(negedge clk);
      chk($sformatf("tie%0d_idle_gap", i), mem_rd_en, 1'b0);
      next_cycle();
      @(negedge clk);
      chk($sformatf("tie%0d_rd_en", i), mem_rd_en, 1'b1);
      chk($sformatf("tie%0d_addr", i), mem_addr, exp_port ? 16'h0200 : 16'h0100);
      next_cycle();
      mem_rd_valid = 1'b1;
      mem_rd_data  = 32'hA000_0000 + i;
      @(negedge clk);
      chk($sformatf("tie%0d_rd_valid", i), rd_valid, oh);
      next_cycle();
      mem_rd_valid = 1'b0;
    end
    clear_inputs();
    next_cycle();

    // Read timeout: memory never answers; junk on mem_rd_data must not leak.
    req_rd      = 2'b10;
    req_addr    = {16'h0300, 16'h0000};
    mem_rd_data = 32'hFFFFFFFF;
    @(negedge clk);
    chk("to_accept_err", bus_err, 1'b0);
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("to_c%0d_wait", c), {mem_rd_en, rd_valid, bus_err}, 4'b1000);
      next_cycle();
    end
    @(negedge clk);
    chk("to_c5_rd_valid", rd_valid, 2'b10);
    chk("to_c5_rd_data", rd_data, 32'h0);
    chk("to_c5_bus_err", bus_err, 1'b1);
    next_cycle();
    // Next request is accepted straight away.
    clear_inputs();
    req_wr      = 2'b01;
    req_addr    = {16'h0000, 16'h0010};
    req_wr_data = {32'h0, 32'hAAAA5555};
    @(negedge clk);
    chk("to_next_idle", mem_wr_en, 1'b0);
    next_cycle();
    @(negedge clk);
    chk("to_next_wr_done", wr_done, 2'b01);
    chk("to_next_wdata", mem_wr_data, 32'hAAAA5555);
    next_cycle();
    clear_inputs();
    next_cycle();

    // Reset during RD abandons the read; a late mem_rd_valid is ignored.
    req_rd   = 2'b01;
    req_addr = {16'h0000, 16'h0444};
    next_cycle();
    @(negedge clk);
    chk("mr_rd_en", mem_rd_en, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_rst_outputs", {mem_rd_en, mem_wr_en, rd_valid, wr_done, bus_err}, 7'b0);
    chk("mr_rst_addr", mem_addr, 16'hFFFF);
    next_cycle();
    rst_n        = 1'b1;
    req_rd       = 2'b00;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 32'h12345678;
    @(negedge clk);
    chk("mr_late_rd_valid", rd_valid, 2'b00);
    chk("mr_late_rd_data", rd_data, 32'h0);
    chk("mr_late_rd_en", mem_rd_en, 1'b0);
    next_cycle();
    mem_rd_valid = 1'b0;
    @(negedge clk);
    chk("mr_after_rd_valid", rd_valid, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
